// File: rtl/prll_bs_pkg.sv
// -----------------------------------------------------------------------------
// prll_bs_pkg
// Shared definitions for the parallel-bus responder endpoint:
//   - bit positions of every field in the 65-bit bus packet
//   - responder FSM state encoding (rspndr_st_t)
//   - packed packet struct (prll_pkt_t) and pack/unpack helpers
// Packet map: [64:62] dst, [61:59] src, [58] wr, [57] rsp, [56] err,
//             [55:32] addr, [31:0] data.
// -----------------------------------------------------------------------------
package prll_bs_pkg;

  localparam int PKT_BITS = 65;

  localparam int DST_MSB  = 64;
  localparam int DST_LSB  = 62;
  localparam int SRC_MSB  = 61;
  localparam int SRC_LSB  = 59;
  localparam int WR_BIT   = 58;
  localparam int RSP_BIT  = 57;
  localparam int ERR_BIT  = 56;
  localparam int ADDR_MSB = 55;
  localparam int ADDR_LSB = 32;
  localparam int DATA_MSB = 31;
  localparam int DATA_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_POP  = 3'd1,
    ST_CHK  = 3'd2,
    ST_REQ  = 3'd3,
    ST_RESP = 3'd4
  } rspndr_st_t;

  typedef struct packed {
    logic [2:0]  dst;
    logic [2:0]  src;
    logic        wr;
    logic        rsp;
    logic        err;
    logic [23:0] addr;
    logic [31:0] data;
  } prll_pkt_t;

  // Field-by-field split of a raw bus word into the packet struct.
  function automatic prll_pkt_t pkt_unpack(input logic [PKT_BITS-1:0] w);
    prll_pkt_t p;
    p.dst  = w[DST_MSB:DST_LSB];
    p.src  = w[SRC_MSB:SRC_LSB];
    p.wr   = w[WR_BIT];
    p.rsp  = w[RSP_BIT];
    p.err  = w[ERR_BIT];
    p.addr = w[ADDR_MSB:ADDR_LSB];
    p.data = w[DATA_MSB:DATA_LSB];
    return p;
  endfunction

  // Inverse of pkt_unpack: place each struct field at its bus position.
  function automatic logic [PKT_BITS-1:0] pkt_pack(input prll_pkt_t p);
    logic [PKT_BITS-1:0] w;
    w                    = '0;
    w[DST_MSB:DST_LSB]   = p.dst;
    w[SRC_MSB:SRC_LSB]   = p.src;
    w[WR_BIT]            = p.wr;
    w[RSP_BIT]           = p.rsp;
    w[ERR_BIT]           = p.err;
    w[ADDR_MSB:ADDR_LSB] = p.addr;
    w[DATA_MSB:DATA_LSB] = p.data;
    return w;
  endfunction

endpackage

// File: rtl/prll_bs_rspndr_if.sv
// -----------------------------------------------------------------------------
// prll_bs_rspndr_if
// Bundles the responder's bus-FIFO pair and its peripheral req/ack port.
//   master : the responder (pops requests, pushes responses, drives prph_req)
//   slave  : the environment (FIFO pair + peripheral register block)
// Signals:
//   pndng/pop/D_pop        bus-to-device FIFO (show-ahead head word)
//   push/D_push            device-to-bus FIFO
//   prph_req/wr/addr/wdata peripheral access, held until prph_ack
//   prph_ack/rdata/err     peripheral completion
// -----------------------------------------------------------------------------
interface prll_bs_rspndr_if #(
  parameter int bits = 65
);

  logic            pndng;
  logic            pop;
  logic [bits-1:0] D_pop;
  logic            push;
  logic [bits-1:0] D_push;
  logic            prph_req;
  logic            prph_wr;
  logic [23:0]     prph_addr;
  logic [31:0]     prph_wdata;
  logic            prph_ack;
  logic [31:0]     prph_rdata;
  logic            prph_err;

  modport master (
    input  pndng, D_pop, prph_ack, prph_rdata, prph_err,
    output pop, push, D_push, prph_req, prph_wr, prph_addr, prph_wdata
  );

  modport slave (
    output pndng, D_pop, prph_ack, prph_rdata, prph_err,
    input  pop, push, D_push, prph_req, prph_wr, prph_addr, prph_wdata
  );

endinterface

// File: rtl/prll_rspndr_tmo_cntr.sv
// -----------------------------------------------------------------------------
// prll_rspndr_tmo_cntr
// 16-bit peripheral-ack timeout counter. Only instantiated when the responder
// is built with RSPNDR_TMO_EN.
// Ports:
//   clk, reset  clock, asynchronous active-low reset
//   en          count while the responder waits in REQ
//   clr         return to zero (access finished); dominates en
//   expired     high in the cycle the count equals lim while enabled
// -----------------------------------------------------------------------------
module prll_rspndr_tmo_cntr #(
  parameter logic [15:0] lim = 16'd254
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [15:0] cnt_q;

  // The count equals the number of completed REQ cycles, so expiry at lim
  // means the request has been held for lim+1 cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign expired = en && (cnt_q == lim);

endmodule

// File: rtl/prll_bs_rspndr.sv
// -----------------------------------------------------------------------------
// prll_bs_rspndr
// Device-side responder for the parallel bus. Drains one request packet at a
// time from the bus-to-device FIFO, runs it as a register access on the
// peripheral port and, for unicast requests, pushes a response packet back
// to the requester.
// Parameters: bits (must be 65), id (own address), bdcst (broadcast address),
//             tmo_cyc (ack timeout, 1..65535).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    prll_bs_rspndr_if.master (FIFO pair + peripheral port)
//   busy   high whenever the FSM is not idle
// Build option: RSPNDR_TMO_EN adds the peripheral ack timeout; without it the
// responder waits in REQ for prph_ack indefinitely.
// -----------------------------------------------------------------------------
module prll_bs_rspndr
  import prll_bs_pkg::*;
#(
  parameter int          bits    = 65,
  parameter logic [2:0]  id      = 3'd1,
  parameter logic [2:0]  bdcst   = 3'b111,
  parameter int          tmo_cyc = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  prll_bs_rspndr_if.master     bus,
  output logic                 busy
);

  if (bits != PKT_BITS || tmo_cyc < 1 || tmo_cyc > 65535) begin : g_bad_cfg
    $error("prll_bs_rspndr: bits must be 65 and tmo_cyc within 1..65535");
  end

  rspndr_st_t      state_q, state_d;
  prll_pkt_t       req_q;
  prll_pkt_t       rsp_pkt;
  logic            prph_wr_q;
  logic [23:0]     prph_addr_q;
  logic [31:0]     prph_wdata_q;
  logic [bits-1:0] d_push_q;
  logic            is_bcast;
  logic            chk_accept;
  logic            tmo_hit;
  logic            req_done;
  logic            req_err_unused;

  // The err bit of an incoming request carries no meaning for the target.
  assign req_err_unused = req_q.err;

  assign is_bcast = (req_q.dst == bdcst);

  // Accept only requests (not stray responses) aimed at us or at everyone,
  // and reject broadcast reads since nobody could answer them coherently.
  assign chk_accept = !req_q.rsp
                   && ((req_q.dst == id) || is_bcast)
                   && !(is_bcast && !req_q.wr);

  // An access finishes on ack or, when the timeout is built in, on expiry.
  assign req_done = (state_q == ST_REQ) && (bus.prph_ack || tmo_hit);

`ifdef RSPNDR_TMO_EN
  prll_rspndr_tmo_cntr #(
    .lim (16'(tmo_cyc - 1))
  ) u_tmo_cntr (
    .clk     (clk),
    .reset   (reset),
    .en      (state_q == ST_REQ),
    .clr     (req_done),
    .expired (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  // State register; reset aborts any in-flight access immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one packet in flight, pndng only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.pndng) state_d = ST_POP;
      ST_POP:  state_d = ST_CHK;
      ST_CHK:  state_d = chk_accept ? ST_REQ : ST_IDLE;
      ST_REQ:  if (req_done) state_d = is_bcast ? ST_IDLE : ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore output decode: strobes and prph_req follow the state directly, so
  // prph_req falls as soon as reset forces the state back to IDLE.
  always_comb begin
    bus.pop      = 1'b0;
    bus.push     = 1'b0;
    bus.prph_req = 1'b0;
    busy         = 1'b1;
    unique case (state_q)
      ST_IDLE: busy         = 1'b0;
      ST_POP:  bus.pop      = 1'b1;
      ST_CHK:  ;
      ST_REQ:  bus.prph_req = 1'b1;
      ST_RESP: bus.push     = 1'b1;
      default: busy         = 1'b0;
    endcase
  end

  // Response assembly. An ack that lands in the timeout cycle still wins;
  // a genuine timeout reports err with zeroed data.
  always_comb begin
    rsp_pkt      = '0;
    rsp_pkt.dst  = req_q.src;
    rsp_pkt.src  = id;
    rsp_pkt.wr   = req_q.wr;
    rsp_pkt.rsp  = 1'b1;
    rsp_pkt.addr = req_q.addr;
    if (bus.prph_ack) begin
      rsp_pkt.err  = bus.prph_err;
      rsp_pkt.data = req_q.wr ? req_q.data : bus.prph_rdata;
    end else begin
      rsp_pkt.err  = 1'b1;
      rsp_pkt.data = '0;
    end
  end

  // Request capture at the end of POP, peripheral command setup in CHK and
  // response capture as the access completes; all held until overwritten.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q        <= '0;
      prph_wr_q    <= 1'b0;
      prph_addr_q  <= '0;
      prph_wdata_q <= '0;
      d_push_q     <= '0;
    end else begin
      if (state_q == ST_POP) begin
        req_q <= pkt_unpack(bus.D_pop);
      end
      if ((state_q == ST_CHK) && chk_accept) begin
        prph_wr_q    <= req_q.wr;
        prph_addr_q  <= req_q.addr;
        prph_wdata_q <= req_q.data;
      end
      if (req_done && !is_bcast) begin
        d_push_q <= pkt_pack(rsp_pkt);
      end
    end
  end

  assign bus.prph_wr    = prph_wr_q;
  assign bus.prph_addr  = prph_addr_q;
  assign bus.prph_wdata = prph_wdata_q;
  assign bus.D_push     = d_push_q;

endmodule

// File: tb/tb_prll_bs_rspndr.sv
// -----------------------------------------------------------------------------
// tb_prll_bs_rspndr
// Scoreboard bench for prll_bs_rspndr: a queue-backed FIFO model feeds
// requests, a peripheral model answers accesses, expected peripheral commands
// and response packets are queued when stimulus is applied and compared as
// the DUT produces them. Timeout scenario is built with RSPNDR_TMO_EN.
// -----------------------------------------------------------------------------
module tb_prll_bs_rspndr;

  typedef struct packed {
    logic        wr;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        no_ack;
  } prph_exp_t;

  localparam logic [2:0] MY_ID = 3'd1;
  localparam logic [2:0] BCAST = 3'b111;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic busy;

  int total_checks = 0;
  int bad_checks   = 0;
  int cyc          = 0;
  int pops         = 0;
  int pushes       = 0;
  int req_starts   = 0;
  int req_cycles   = 0;
  int ack_dly      = 0;

  logic [64:0] fifo_q[$];
  logic [64:0] rsp_q[$];
  prph_exp_t   prph_q[$];
  int          pop_times[$];

  prll_bs_rspndr_if #(.bits(65)) ifc ();

  prll_bs_rspndr #(
    .bits    (65),
    .id      (MY_ID),
    .bdcst   (BCAST),
    .tmo_cyc (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master),
    .busy  (busy)
  );

  // Free-running clock and cycle counter used for pop spacing.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [64:0] obs, input logic [64:0] exp_v);
    total_checks++;
    if (obs !== exp_v) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Queue one request and derive what the DUT should do with it.
  task automatic applyStimulus(input logic [2:0] dst, input logic [2:0] src, input logic wr,
                               input logic rsp, input logic [23:0] addr, input logic [31:0] data,
                               input logic [31:0] rdata, input logic err, input logic no_ack,
                               input logic lost);
    prph_exp_t   e;
    logic        accept;
    logic        rsp_err;
    logic [31:0] rsp_data;
    fifo_q.push_back({dst, src, wr, rsp, 1'b0, addr, data});
    accept = !rsp && (dst == MY_ID || dst == BCAST) && !(dst == BCAST && !wr);
    if (accept) begin
      e.wr = wr; e.addr = addr; e.wdata = data; e.rdata = rdata; e.err = err; e.no_ack = no_ack;
      prph_q.push_back(e);
      if (dst == MY_ID && !lost) begin
        rsp_err  = no_ack ? 1'b1 : err;
        rsp_data = no_ack ? 32'h0 : (wr ? data : rdata);
        rsp_q.push_back({src, MY_ID, wr, 1'b1, rsp_err, addr, rsp_data});
      end
    end
  endtask

  // Bounded wait for every queue to drain and the DUT to go idle.
  task automatic waitIdle(input string tag);
    int left;
    left = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      left = fifo_q.size() + rsp_q.size() + prph_q.size() + int'(busy);
      if (left == 0) break;
    end
    checkOutput(tag, left, 0);
  endtask

  // Bus-to-device FIFO model: show-ahead head word; an entry is retired on
  // the falling edge after the DUT's pop cycle, once it has been captured.
  initial begin
    logic pop_seen;
    pop_seen  = 1'b0;
    ifc.pndng = 1'b0;
    ifc.D_pop = '0;
    forever begin
      @(negedge clk);
      if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_seen = ifc.pop;
      if (ifc.pop) begin
        pops++;
        pop_times.push_back(cyc);
      end
      ifc.pndng = (fifo_q.size() > 0);
      ifc.D_pop = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end
  end

  // Peripheral model: checks the command at the start of each access and
  // acks ack_dly cycles later unless the access is meant to time out.
  initial begin
    logic      in_access;
    int        wait_cnt;
    prph_exp_t cur;
    in_access      = 1'b0;
    wait_cnt       = 0;
    cur            = '0;
    ifc.prph_ack   = 1'b0;
    ifc.prph_rdata = '0;
    ifc.prph_err   = 1'b0;
    forever begin
      @(negedge clk);
      ifc.prph_ack = 1'b0;
      if (ifc.prph_req) begin
        req_cycles++;
        if (!in_access) begin
          in_access = 1'b1;
          wait_cnt  = 0;
          req_starts++;
          if (prph_q.size() == 0) begin
            checkOutput("req_unexp", ifc.prph_req, 0);
            cur        = '0;
            cur.no_ack = 1'b1;
          end else begin
            cur = prph_q.pop_front();
            checkOutput("prph_wr", ifc.prph_wr, cur.wr);
            checkOutput("prph_addr", ifc.prph_addr, cur.addr);
            checkOutput("prph_wdata", ifc.prph_wdata, cur.wdata);
          end
        end
        if (!cur.no_ack && wait_cnt == ack_dly) begin
          ifc.prph_ack   = 1'b1;
          ifc.prph_rdata = cur.rdata;
          ifc.prph_err   = cur.err;
        end
        wait_cnt++;
      end else begin
        in_access = 1'b0;
      end
    end
  end

  // Response monitor: pops the scoreboard on each push.
  initial begin
    forever begin
      @(negedge clk);
      if (ifc.pop || ifc.push) checkOutput("pop_push_excl", ifc.pop & ifc.push, 0);
      if (ifc.push) begin
        pushes++;
        if (rsp_q.size() == 0) checkOutput("push_unexp", ifc.push, 0);
        else checkOutput("d_push", ifc.D_push, rsp_q.pop_front());
      end
    end
  end

  // Hang guard.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got=hang expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    int p0, q0, r0, c0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_pop", ifc.pop, 0);
    checkOutput("rst_push", ifc.push, 0);
    checkOutput("rst_req", ifc.prph_req, 0);
    checkOutput("rst_wr", ifc.prph_wr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_addr", ifc.prph_addr, 0);
    checkOutput("rst_wdata", ifc.prph_wdata, 0);
    checkOutput("rst_dpush", ifc.D_push, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] unicast write");
    ack_dly = 2;
    p0 = pops; q0 = pushes;
    applyStimulus(3'd1, 3'd0, 1'b1, 1'b0, 24'h000010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0);
    waitIdle("wr_drain");
    checkOutput("wr_pops", pops - p0, 1);
    checkOutput("wr_pushes", pushes - q0, 1);

    $display("[TB] unicast reads");
    ack_dly = 0;
    q0 = pushes;
    applyStimulus(3'd1, 3'd2, 1'b0, 1'b0, 24'h000024, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b0);
    waitIdle("rd_drain");
    applyStimulus(3'd1, 3'd5, 1'b0, 1'b0, 24'hABCDEF, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
    waitIdle("rd_err_drain");
    checkOutput("rd_pushes", pushes - q0, 2);

    $display("[TB] broadcast");
    ack_dly = 1;
    p0 = pops; q0 = pushes; r0 = req_starts;
    applyStimulus(3'd7, 3'd3, 1'b1, 1'b0, 24'h000100, 32'h0BADF00D, 32'h0, 1'b0, 1'b0, 1'b0);
    waitIdle("bc_wr_drain");
    checkOutput("bc_wr_reqs", req_starts - r0, 1);
    applyStimulus(3'd7, 3'd3, 1'b0, 1'b0, 24'h000104, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    waitIdle("bc_rd_drain");
    checkOutput("bc_reqs", req_starts - r0, 1);
    checkOutput("bc_pops", pops - p0, 2);
    checkOutput("bc_pushes", pushes - q0, 0);

    $display("[TB] drops");
    p0 = pops; q0 = pushes; r0 = req_starts;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) applyStimulus(3'd1, 3'd4, 1'b1, 1'b1, 24'h000200, 32'h11111111, 32'h0, 1'b0, 1'b0, 1'b0);
      else        applyStimulus(3'd2, 3'd4, 1'b1, 1'b0, 24'h000204, 32'h22222222, 32'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk); #1;
        if (ifc.pop) break;
      end
      checkOutput("drop_pop_seen", ifc.pop, 1);
      @(negedge clk); #1;
      checkOutput("drop_busy_chk", busy, 1);
      @(negedge clk); #1;
      checkOutput("drop_busy_idle", busy, 0);
      waitIdle("drop_drain");
    end
    checkOutput("drop_pops", pops - p0, 2);
    checkOutput("drop_reqs", req_starts - r0, 0);
    checkOutput("drop_pushes", pushes - q0, 0);

    $display("[TB] back-to-back");
    ack_dly = 0;
    c0 = pop_times.size();
    applyStimulus(3'd1, 3'd6, 1'b0, 1'b0, 24'h000300, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd1, 3'd2, 1'b1, 1'b0, 24'h000304, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b0, 1'b0);
    waitIdle("b2b_drain");
    checkOutput("b2b_pop_cnt", pop_times.size() - c0, 2);
    if (pop_times.size() - c0 == 2) checkOutput("b2b_gap", pop_times[c0+1] - pop_times[c0], 5);

    $display("[TB] reset during REQ");
    q0 = pushes;
    applyStimulus(3'd1, 3'd0, 1'b1, 1'b0, 24'h000400, 32'h77777777, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (ifc.prph_req) break;
    end
    checkOutput("mid_req_seen", ifc.prph_req, 1);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_req", ifc.prph_req, 0);
    checkOutput("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checkOutput("mid_rst_push", pushes - q0, 0);
    checkOutput("mid_rst_idle", busy, 0);

`ifdef RSPNDR_TMO_EN
    $display("[TB] ack timeout");
    r0 = req_cycles;
    applyStimulus(3'd1, 3'd3, 1'b0, 1'b0, 24'h000500, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    waitIdle("tmo_drain");
    checkOutput("tmo_req_cycles", req_cycles - r0, 8);
`endif

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
